// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding and default widths/reset vector.
package pc_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-PC selection: flush > redirect > sequential, with word alignment of targets
// and detection of misaligned targets.
module pc_next_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_cur,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            consume,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_load,
  output logic            misalign
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] target_raw_s;
  logic            use_target_s;

  // Priority mux; the low two bits of any accepted target are dropped.
  always_comb begin
    target_raw_s = redirect_target;
    use_target_s = 1'b0;
    pc_next      = pc_cur;
    pc_load      = 1'b0;
    if (flush) begin
      target_raw_s = flush_pc;
      use_target_s = 1'b1;
    end else if (consume && redirect_valid) begin
      use_target_s = 1'b1;
    end else begin
      use_target_s = 1'b0;
    end
    if (use_target_s) begin
      pc_next = {target_raw_s[XLEN-1:2], 2'b00};
      pc_load = 1'b1;
    end else if (consume) begin
      pc_next = pc_cur + PC_STEP;
      pc_load = 1'b1;
    end else begin
      pc_load = 1'b0;
    end
    misalign = use_target_s && (target_raw_s[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, issues one instruction-memory request at a time and
// buffers the returned instruction until execute consumes it.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = INSTR_W,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state_r, state_nxt;
  logic [XLEN-1:0] pc_r, instr_r, pc_nxt_s;
  logic            instr_valid_r, kill_r, misalign_r;
  logic            kill_nxt, valid_nxt, capture_s, consume_s, pc_load_s, misalign_s;

  assign consume_s = (state_r == ST_HOLD) && instr_ready;

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc_cur          (pc_r),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .consume         (consume_s),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_next         (pc_nxt_s),
    .pc_load         (pc_load_s),
    .misalign        (misalign_s)
  );

  // Next state; a flush kills an outstanding request so its response is discarded later.
  always_comb begin
    state_nxt = state_r;
    kill_nxt  = kill_r;
    valid_nxt = instr_valid_r;
    capture_s = 1'b0;
    if (flush) begin
      valid_nxt = 1'b0;
      if ((state_r == ST_REQ) || ((state_r == ST_WAIT) && !imem_rvalid)) begin
        kill_nxt  = 1'b1;
        state_nxt = ST_WAIT;
      end else begin
        kill_nxt  = 1'b0;
        state_nxt = ST_REQ;
      end
    end else begin
      case (state_r)
        ST_RST:  state_nxt = ST_REQ;
        ST_REQ:  state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid && kill_r) begin
            kill_nxt  = 1'b0;
            state_nxt = ST_REQ;
          end else if (imem_rvalid) begin
            capture_s = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            valid_nxt = 1'b0;
            state_nxt = ST_REQ;
          end else begin
            state_nxt = ST_HOLD;
          end
        end
        default: state_nxt = ST_RST;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RST;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath registers: PC, instruction buffer, kill and sticky misalign flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      instr_r       <= '0;
      instr_valid_r <= 1'b0;
      kill_r        <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      instr_valid_r <= valid_nxt;
      kill_r        <= kill_nxt;
      if (capture_s) begin
        instr_r <= imem_rdata;
      end
      if (pc_load_s) begin
        pc_r <= pc_nxt_s;
      end
      if (misalign_s) begin
        misalign_r <= 1'b1;
      end
    end
  end

  assign imem_req     = (state_r == ST_REQ);
  assign imem_addr    = pc_r;
  assign instr_valid  = instr_valid_r;
  assign instr        = instr_r;
  assign pc_out       = pc_r;
  assign pc_plus4     = pc_r + PC_STEP;
  assign misalign_err = misalign_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a transaction-level model of the fetch
// contract plus a behavioural instruction memory with random latency.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_rvalid, instr_valid, instr_ready;
  logic        redirect_valid, flush, misalign_err;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out, pc_plus4, redirect_target, flush_pc;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .flush(flush), .flush_pc(flush_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model state
  logic [31:0] m_pc, mem_addr;
  logic        m_valid, m_mis, exp_req, pending, live;
  int          mem_cnt;
  logic [31:0] req_log[$];

  // Stimulus knobs
  int          lat_lo = 1, lat_hi = 1, ready_pct = 100, redir_pct = 0, flush_pct = 0, mis_pct = 0;
  int          dir_flush_mode = 0;
  logic [31:0] dir_flush_pc = 32'h0;
  logic        dir_redirect = 1'b0;
  logic [31:0] dir_target = 32'h0;

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(99) >= mis_pct) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic idle_inputs();
    imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0; flush = 1'b0; flush_pc = 32'h0;
  endtask

  task automatic reset_model();
    m_pc = RESET_PC; m_valid = 1'b0; m_mis = 1'b0; pending = 1'b0; live = 1'b0;
    mem_cnt = 0; exp_req = 1'b1;
  endtask

  // One clock: check outputs against the model, play memory, drive inputs, advance model.
  task automatic step();
    logic        fl, rv, was_pending, cons_req, redir, cons, nxt_req;
    logic [31:0] fpc, tgt;
    @(posedge clk); #1;
    check_eq("imem_req", imem_req, exp_req);
    check_eq("instr_valid", instr_valid, m_valid);
    check_eq("pc_out", pc_out, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("misalign_err", misalign_err, m_mis);
    if (imem_req) begin
      check_eq("imem_addr", imem_addr, m_pc);
      check_eq("one_outstanding", pending, 1'b0);
      req_log.push_back(imem_addr);
    end
    if (m_valid) check_eq("instr", instr, mem_word(m_pc));

    was_pending = pending;
    rv = 1'b0;
    if (pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin rv = 1'b1; pending = 1'b0; end
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(mem_addr) : $urandom;
    if (imem_req) begin
      pending = 1'b1; live = 1'b1; mem_addr = imem_addr;
      mem_cnt = $urandom_range(lat_hi, lat_lo);
    end

    fl  = (dir_flush_mode == 0 && !dir_redirect) ? ($urandom_range(99) < flush_pct) : 1'b0;
    fpc = rand_addr();
    if (dir_flush_mode == 1 && was_pending && !rv) begin
      fl = 1'b1; fpc = dir_flush_pc; dir_flush_mode = 0;
    end else if (dir_flush_mode == 2 && rv) begin
      fl = 1'b1; fpc = dir_flush_pc; dir_flush_mode = 0;
    end
    cons_req = ($urandom_range(99) < ready_pct);
    redir    = ($urandom_range(99) < redir_pct);
    tgt      = rand_addr();
    if (dir_redirect && m_valid) begin
      cons_req = 1'b1; redir = 1'b1; tgt = dir_target; dir_redirect = 1'b0;
    end
    flush = fl; flush_pc = fpc; instr_ready = cons_req;
    redirect_valid = redir; redirect_target = tgt;

    cons = m_valid && cons_req;
    nxt_req = 1'b0;
    if (fl) begin
      m_pc = {fpc[31:2], 2'b00};
      m_mis = m_mis | (fpc[1:0] != 2'b00);
      m_valid = 1'b0;
      if (pending) live = 1'b0;
      else nxt_req = 1'b1;
    end else begin
      if (rv && live) m_valid = 1'b1;
      else if (rv) nxt_req = 1'b1;
      if (cons) begin
        m_valid = 1'b0;
        nxt_req = 1'b1;
        if (redir) begin
          m_pc = {tgt[31:2], 2'b00};
          m_mis = m_mis | (tgt[1:0] != 2'b00);
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
    exp_req = nxt_req;
  endtask

  task automatic apply_reset_midcycle();
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check_eq("rst_pc_out", pc_out, RESET_PC);
    check_eq("rst_instr_valid", instr_valid, 1'b0);
    check_eq("rst_imem_req", imem_req, 1'b0);
    check_eq("rst_misalign", misalign_err, 1'b0);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    reset_model();
  endtask

  initial begin
    int base;
    logic found;
    idle_inputs();
    #1;
    check_eq("por_pc_out", pc_out, RESET_PC);
    check_eq("por_instr", instr, 32'h0);
    check_eq("por_instr_valid", instr_valid, 1'b0);
    check_eq("por_imem_req", imem_req, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    reset_model();

    // Sequential fetch, 1-cycle memory, always ready
    req_log.delete();
    repeat (9) step();
    check_eq("seq_count", req_log.size() >= 3, 1'b1);
    if (req_log.size() >= 3) begin
      check_eq("seq_addr0", req_log[0], 32'h0000_0000);
      check_eq("seq_addr1", req_log[1], 32'h0000_0004);
      check_eq("seq_addr2", req_log[2], 32'h0000_0008);
    end

    // Redirect to 0x100
    dir_redirect = 1'b1; dir_target = 32'h0000_0100;
    for (int i = 0; i < 40 && dir_redirect; i++) step();
    check_eq("redirect_used", dir_redirect, 1'b0);
    repeat (6) step();

    // Flush during WAIT with slow memory
    lat_lo = 3; lat_hi = 3;
    dir_flush_mode = 1; dir_flush_pc = 32'h0000_0200;
    for (int i = 0; i < 40 && dir_flush_mode != 0; i++) step();
    check_eq("flush_wait_used", dir_flush_mode, 0);
    repeat (12) step();

    // Flush coincident with the response
    lat_lo = 1; lat_hi = 2;
    dir_flush_mode = 2; dir_flush_pc = 32'h0000_0300;
    for (int i = 0; i < 40 && dir_flush_mode != 0; i++) step();
    check_eq("flush_rvalid_used", dir_flush_mode, 0);
    repeat (8) step();

    // Misaligned redirect
    dir_redirect = 1'b1; dir_target = 32'h0000_0102;
    for (int i = 0; i < 40 && dir_redirect; i++) step();
    repeat (8) step();
    check_eq("misalign_sticky", misalign_err, 1'b1);

    // PC wrap at the top of the address space
    dir_flush_mode = 1; dir_flush_pc = 32'hFFFF_FFFC;
    base = req_log.size();
    repeat (30) step();
    found = 1'b0;
    for (int i = base; i + 1 < req_log.size(); i++)
      if (req_log[i] == 32'hFFFF_FFFC && req_log[i+1] == 32'h0000_0000) found = 1'b1;
    check_eq("wrap_seen", found, 1'b1);

    // Reset while a request is outstanding
    lat_lo = 3; lat_hi = 4;
    for (int i = 0; i < 40 && !(pending && mem_cnt >= 2); i++) step();
    check_eq("reached_wait", pending, 1'b1);
    apply_reset_midcycle();
    repeat (10) step();

    // Randomized traffic
    lat_lo = 1; lat_hi = 4; ready_pct = 70; redir_pct = 25; flush_pct = 8; mis_pct = 20;
    repeat (3000) step();
    flush_pct = 0;
    for (int i = 0; i < 40 && !(pending && mem_cnt >= 2); i++) step();
    apply_reset_midcycle();
    flush_pct = 8;
    repeat (500) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch stage directly upstream of the branch decision logic.
- Holds the architectural PC and issues one instruction-memory request at a time.
- Buffers the returned instruction until the execute side consumes it.
- On consumption, advances the PC to PC+4 or to the redirect target produced from BranchTaken/jump. A separate flush input can redirect fetch from any state and discards in-flight responses.

Parameters:
- XLEN, 32, PC/instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  one-cycle request pulse to instruction memory.
- imem_addr  output  XLEN  request address; equals pc_out while imem_req=1.
- imem_rvalid  input  1  response valid, at least 1 cycle after imem_req.
- imem_rdata  input  XLEN  response instruction.
- instr_valid  output  1  instr/pc_out hold a consumable instruction.
- instr  output  XLEN  buffered instruction.
- pc_out  output  XLEN  PC of the current/buffered instruction.
- pc_plus4  output  XLEN  pc_out+4, modulo 2^XLEN.
- instr_ready  input  1  execute consumes the instruction this cycle; meaningful only when instr_valid=1.
- redirect_valid  input  1  BranchTaken OR jump for the consumed instruction; sampled only with instr_valid & instr_ready.
- redirect_target  input  XLEN  branch/jump target.
- flush  input  1  trap/exception redirect; honoured in every state.
- flush_pc  input  XLEN  flush target.
- misalign_err  output  1  sticky flag, set when an accepted target has bits[1:0]!=0.

Behaviour:
- Reset (async, rst_n=0): state=RST, pc_out=RESET_PC, instr=0, instr_valid=0, imem_req=0, kill=0, misalign_err=0. Deassertion is synchronised by the caller.
- States:
  - RST: next cycle -> REQ.
  - REQ: imem_req=1, imem_addr=pc_out -> WAIT.
  - WAIT: on imem_rvalid, if kill=0 capture imem_rdata into instr, set instr_valid=1 -> HOLD. If kill=1, discard, clear kill -> REQ.
  - HOLD: instr_valid=1. On instr_ready, clear instr_valid; pc_out <= redirect_valid ? redirect_target : pc_out+4 -> REQ.
- Latency: reset release to first imem_req is 1 cycle. Consume to next imem_req is 1 cycle. Minimum 3 cycles per instruction with a 1-cycle memory.
- Flush (highest priority, any state): pc_out <= flush_pc and instr_valid <= 0.
  - In REQ, or in WAIT without imem_rvalid that cycle: request is outstanding, so kill <= 1 and -> WAIT.
  - In WAIT with imem_rvalid the same cycle: drop the response -> REQ, kill stays 0.
  - In RST or HOLD: -> REQ.
  - flush with instr_ready in HOLD: flush wins; the redirect is ignored.
- Target alignment: an accepted redirect_target or flush_pc has bits[1:0] forced to 0, and misalign_err is set if they were nonzero. misalign_err clears only on reset.
- Wrap: pc_out=32'hFFFF_FFFC advancing sequentially gives 32'h0000_0000; no error.
- Protocol: at most one outstanding request. imem_rvalid outside WAIT is ignored. instr/pc_out stay stable while instr_valid=1 and not consumed.
- Reset mid-WAIT: the response is lost, and memory must drop it on reset.

Decomposition:
- Shared package: state enum (RST, REQ, WAIT, HOLD), RESET_PC default, instruction width constant.
- One natural sub-module: pc_next_sel, a combinational next-PC mux with priority flush > redirect > +4, plus alignment masking and the misalign detect.

Test Plan:
- Reset release, memory latency 1, instr_ready held 1 -> imem_addr sequence 0x0, 0x4, 0x8; each instr_valid is 1 cycle after its rvalid.
- Consume with redirect_valid=1, target=0x100 -> next imem_addr=0x100; pc_plus4=0x104 once captured.
- flush=1, flush_pc=0x200 during WAIT (latency 3) -> old rdata never appears on instr; next imem_addr=0x200.
- flush and imem_rvalid in the same WAIT cycle -> response dropped; next cycle imem_req with addr=flush_pc.
- redirect_target=0x102 -> imem_addr=0x100 and misalign_err=1 until rst_n low.
- RESET_PC=0xFFFFFFFC with sequential consume -> next imem_addr=0x0; rst_n pulse mid-WAIT -> pc_out=RESET_PC asynchronously and instr_valid=0.
